// File: rtl/modulo_varredura_preset.sv
// modulo_varredura_preset
// Row-scanning driver for an LED dot matrix with a writable bank of preset
// character patterns, frame-synchronous character switching and blink.
module modulo_varredura_preset #(
    parameter  int COLS         = 5,
    parameter  int ROWS         = 7,
    parameter  int NUM_PATTERNS = 4,
    parameter  int DIV          = 50000,
    parameter  int BLINK_FRAMES = 32,
    localparam int SEL_W        = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1,
    localparam int ROW_W        = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SEL_W-1:0] sel,
    input  logic             blink_en,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_pat,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [COLS-1:0]  wr_data,
    output logic [ROWS-1:0]  row,
    output logic [COLS-1:0]  col,
    output logic             frame_start
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(DIV - 1);
    localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(ROWS - 1);
    localparam logic [FC_W-1:0]  FC_LAST     = FC_W'(BLINK_FRAMES - 1);
    localparam logic [SEL_W:0]   NUM_PAT_EXT = (SEL_W + 1)'(NUM_PATTERNS);
    localparam logic [ROW_W:0]   ROWS_EXT    = (ROW_W + 1)'(ROWS);
    localparam logic [ROWS-1:0]  ROW_FIRST   = ROWS'(1);

    logic [DIV_W-1:0] r_div_cnt;
    logic [ROW_W-1:0] r_row_idx;
    logic [SEL_W-1:0] r_active_sel;
    logic [FC_W-1:0]  r_frame_cnt;
    logic             r_visible;
    logic [COLS-1:0]  r_mem [NUM_PATTERNS][ROWS];

    logic             w_tick;
    logic             w_boundary;
    logic [DIV_W-1:0] w_div_next;
    logic [ROW_W-1:0] w_row_idx_next;
    logic [SEL_W-1:0] w_sel_clamped;
    logic [SEL_W-1:0] w_active_sel_next;
    logic [FC_W-1:0]  w_frame_cnt_next;
    logic             w_visible_next;
    logic             w_wr_ok;
    logic [ROWS-1:0]  w_row_onehot;
    logic [COLS-1:0]  w_col_next;

    assign w_tick         = (r_div_cnt == DIV_LAST);
    assign w_boundary     = w_tick && (r_row_idx == ROW_LAST);
    assign w_div_next     = w_tick ? '0 : r_div_cnt + DIV_W'(1);
    assign w_row_idx_next = !w_tick   ? r_row_idx :
                            w_boundary ? '0 : r_row_idx + ROW_W'(1);

    // Out-of-range character requests fall back to character 0
    assign w_sel_clamped     = ({1'b0, sel} < NUM_PAT_EXT) ? sel : '0;
    assign w_active_sel_next = w_boundary ? w_sel_clamped : r_active_sel;

    assign w_wr_ok = wr_en && ({1'b0, wr_row} < ROWS_EXT) && ({1'b0, wr_pat} < NUM_PAT_EXT);

    // Output words are built from next-state values so row and col change together
    assign w_row_onehot = ROW_FIRST << w_row_idx_next;
    assign w_col_next   = w_visible_next ? r_mem[w_active_sel_next][w_row_idx_next] : '0;

    // Blink phase: frame counter only runs while blinking, otherwise steady-on
    always_comb begin
        w_frame_cnt_next = r_frame_cnt;
        w_visible_next   = r_visible;
        if (!blink_en) begin
            w_frame_cnt_next = '0;
            w_visible_next   = 1'b1;
        end else if (w_boundary) begin
            if (r_frame_cnt == FC_LAST) begin
                w_frame_cnt_next = '0;
                w_visible_next   = ~r_visible;
            end else begin
                w_frame_cnt_next = r_frame_cnt + FC_W'(1);
            end
        end
    end

    // Scan state and registered matrix outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt    <= '0;
            r_row_idx    <= '0;
            r_active_sel <= '0;
            r_frame_cnt  <= '0;
            r_visible    <= 1'b1;
            row          <= ROW_FIRST;
            col          <= '0;
            frame_start  <= 1'b0;
        end else begin
            r_div_cnt    <= w_div_next;
            r_row_idx    <= w_row_idx_next;
            r_active_sel <= w_active_sel_next;
            r_frame_cnt  <= w_frame_cnt_next;
            r_visible    <= w_visible_next;
            row          <= w_row_onehot;
            col          <= w_col_next;
            frame_start  <= w_boundary;
        end
    end

    // Pattern memory: cleared on reset, written by the host strobe otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < NUM_PATTERNS; p++) begin
                for (int r = 0; r < ROWS; r++) begin
                    r_mem[p][r] <= '0;
                end
            end
        end else if (w_wr_ok) begin
            r_mem[wr_pat][wr_row] <= wr_data;
        end
    end

endmodule

// File: tb/tb_modulo_varredura_preset.sv
module tb_modulo_varredura_preset;

    localparam int ROWS = 7;
    localparam int NP   = 4;
    localparam int BF   = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] sel;
    logic       blink_en;
    logic       wr_en;
    logic [1:0] wr_pat;
    logic [2:0] wr_row;
    logic [4:0] wr_data;
    logic [6:0] row0, row1;
    logic [4:0] col0, col1;
    logic       fs0, fs1;

    always #5 clk = ~clk;

    modulo_varredura_preset #(.COLS(5), .ROWS(7), .NUM_PATTERNS(4), .DIV(2), .BLINK_FRAMES(BF)) u_dut (
        .clk(clk), .reset(reset), .sel(sel), .blink_en(blink_en), .wr_en(wr_en),
        .wr_pat(wr_pat), .wr_row(wr_row), .wr_data(wr_data),
        .row(row0), .col(col0), .frame_start(fs0));

    modulo_varredura_preset #(.COLS(5), .ROWS(7), .NUM_PATTERNS(4), .DIV(1), .BLINK_FRAMES(BF)) u_dut1 (
        .clk(clk), .reset(reset), .sel(sel), .blink_en(blink_en), .wr_en(wr_en),
        .wr_pat(wr_pat), .wr_row(wr_row), .wr_data(wr_data),
        .row(row1), .col(col1), .frame_start(fs1));

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: time-based view of the scan (row = (t/DIV) mod ROWS)
    logic [4:0] m_mem [NP][ROWS];
    int         m_t    [2];
    int         m_asel [2];
    int         m_bf   [2];
    bit         m_vis  [2];
    bit         m_valid = 1'b0;
    logic [6:0] e_row  [2];
    logic [4:0] e_col  [2];
    logic       e_fs   [2];

    task automatic model_step();
        int dv;
        int r;
        bit bnd;
        for (int k = 0; k < 2; k++) begin
            dv = (k == 0) ? 2 : 1;
            if (reset) begin
                m_t[k] = 0; m_asel[k] = 0; m_bf[k] = 0; m_vis[k] = 1'b1;
                e_row[k] = 7'd1; e_col[k] = 5'd0; e_fs[k] = 1'b0;
            end else begin
                m_t[k]++;
                r   = (m_t[k] / dv) % ROWS;
                bnd = (m_t[k] % (ROWS * dv)) == 0;
                if (bnd) m_asel[k] = (int'(sel) < NP) ? int'(sel) : 0;
                if (!blink_en) begin
                    m_bf[k] = 0; m_vis[k] = 1'b1;
                end else if (bnd) begin
                    m_bf[k]++;
                    if (m_bf[k] == BF) begin
                        m_bf[k]  = 0;
                        m_vis[k] = !m_vis[k];
                    end
                end
                e_row[k] = 7'(1 << r);
                e_col[k] = m_vis[k] ? m_mem[m_asel[k]][r] : 5'd0;
                e_fs[k]  = bnd;
            end
        end
        if (reset) begin
            for (int p = 0; p < NP; p++)
                for (int q = 0; q < ROWS; q++) m_mem[p][q] = 5'd0;
            m_valid = 1'b1;
        end else if (wr_en && int'(wr_row) < ROWS) begin
            m_mem[wr_pat][wr_row] = wr_data;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        if (m_valid) begin
            check("m_row0", row0, e_row[0]);
            check("m_col0", col0, e_col[0]);
            check("m_fs0",  fs0,  e_fs[0]);
            check("m_row1", row1, e_row[1]);
            check("m_col1", col1, e_col[1]);
            check("m_fs1",  fs1,  e_fs[1]);
        end
    endtask

    task automatic wait_fs(input string tag);
        int n = 0;
        while (fs0 !== 1'b1 && n < 100) begin
            cycle();
            n++;
        end
        check({tag, "_fs_seen"}, fs0, 1);
    endtask

    typedef struct {
        bit       rst;
        bit [1:0] sel;
        bit       blk;
        bit [6:0] e_row;
        bit [4:0] e_col;
        bit       e_fs;
    } vec_t;

    vec_t vt [16];
    logic [4:0] pat_a [7];
    logic [4:0] pat_b [7];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pat_a = '{5'b01110, 5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001, 5'b10001};
        pat_b = pat_a;
        pat_b[1] = 5'b11111;

        vt[0]  = '{1'b1, 2'd0, 1'b0, 7'b0000001, 5'd0, 1'b0};
        vt[1]  = '{1'b0, 2'd0, 1'b0, 7'b0000001, 5'd0, 1'b0};
        vt[2]  = '{1'b0, 2'd0, 1'b0, 7'b0000010, 5'd0, 1'b0};
        vt[3]  = '{1'b0, 2'd0, 1'b0, 7'b0000010, 5'd0, 1'b0};
        vt[4]  = '{1'b0, 2'd0, 1'b0, 7'b0000100, 5'd0, 1'b0};
        vt[5]  = '{1'b0, 2'd0, 1'b0, 7'b0000100, 5'd0, 1'b0};
        vt[6]  = '{1'b0, 2'd0, 1'b0, 7'b0001000, 5'd0, 1'b0};
        vt[7]  = '{1'b0, 2'd0, 1'b0, 7'b0001000, 5'd0, 1'b0};
        vt[8]  = '{1'b0, 2'd0, 1'b0, 7'b0010000, 5'd0, 1'b0};
        vt[9]  = '{1'b0, 2'd0, 1'b0, 7'b0010000, 5'd0, 1'b0};
        vt[10] = '{1'b0, 2'd0, 1'b0, 7'b0100000, 5'd0, 1'b0};
        vt[11] = '{1'b0, 2'd0, 1'b0, 7'b0100000, 5'd0, 1'b0};
        vt[12] = '{1'b0, 2'd0, 1'b0, 7'b1000000, 5'd0, 1'b0};
        vt[13] = '{1'b0, 2'd0, 1'b0, 7'b1000000, 5'd0, 1'b0};
        vt[14] = '{1'b0, 2'd0, 1'b0, 7'b0000001, 5'd0, 1'b1};
        vt[15] = '{1'b0, 2'd0, 1'b0, 7'b0000001, 5'd0, 1'b0};

        reset = 1'b0; sel = '0; blink_en = 1'b0;
        wr_en = 1'b0; wr_pat = '0; wr_row = '0; wr_data = '0;
        @(negedge clk);

        // Reset and plain scan at DIV=2
        for (int i = 0; i < 16; i++) begin
            reset    = vt[i].rst;
            sel      = vt[i].sel;
            blink_en = vt[i].blk;
            cycle();
            check($sformatf("vec%0d_row", i), row0, vt[i].e_row);
            check($sformatf("vec%0d_col", i), col0, vt[i].e_col);
            check($sformatf("vec%0d_fs", i),  fs0,  vt[i].e_fs);
        end

        // Load letter A into pattern 1, select it mid-frame
        sel = 2'd1;
        for (int r = 0; r < 7; r++) begin
            wr_en = 1'b1; wr_pat = 2'd1; wr_row = 3'(r); wr_data = pat_a[r];
            cycle();
            check("pre_boundary_col", col0, 0);
        end
        wr_en = 1'b0;
        begin
            int n = 0;
            while (fs0 !== 1'b1 && n < 40) begin
                cycle();
                n++;
                if (fs0 !== 1'b1) check("pre_boundary_col", col0, 0);
            end
            check("a_fs_seen", fs0, 1);
        end
        for (int k = 0; k < 7; k++) begin
            check($sformatf("a_row%0d", k), row0, 32'(1 << k));
            check($sformatf("a_col%0d", k), col0, pat_a[k]);
            cycle();
            cycle();
        end
        check("a_next_fs", fs0, 1);

        // Write to a row on the edge it becomes active, then an invalid row index
        cycle();
        wr_en = 1'b1; wr_pat = 2'd1; wr_row = 3'd1; wr_data = 5'b11111;
        cycle();
        wr_en = 1'b0;
        check("live_wr_row", row0, 7'b0000010);
        check("live_wr_old", col0, pat_a[1]);
        cycle();
        check("live_wr_new", col0, 5'b11111);
        wr_en = 1'b1; wr_pat = 2'd1; wr_row = 3'd7; wr_data = 5'b00000;
        cycle();
        wr_en = 1'b0;
        cycle();
        wait_fs("b");
        for (int k = 0; k < 7; k++) begin
            check($sformatf("b_row%0d", k), row0, 32'(1 << k));
            check($sformatf("b_col%0d", k), col0, pat_b[k]);
            cycle();
            cycle();
        end

        // Blink with two frames per half-period
        cycle();
        blink_en = 1'b1;
        wait_fs("blink1");
        check("blink_on", col0, pat_b[0]);
        cycle();
        wait_fs("blink2");
        check("blink_off_f2", col0, 0);
        cycle(); cycle();
        check("blink_off_f2_r1", col0, 0);
        wait_fs("blink3");
        check("blink_off_f3", col0, 0);
        cycle(); cycle();
        check("blink_off_f3_r1", col0, 0);
        check("blink_scan_row", row0, 7'b0000010);
        blink_en = 1'b0;
        cycle();
        check("blink_drop_col", col0, 5'b11111);

        // Reset in the middle of a frame at row 4
        cycle();
        wait_fs("rst");
        for (int i = 0; i < 8; i++) cycle();
        check("rst_pre_row", row0, 7'b0010000);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("rst_row", row0, 7'b0000001);
        check("rst_col", col0, 0);
        check("rst_fs",  fs0,  0);
        for (int n = 1; n <= 28; n++) begin
            cycle();
            check("rst_mem_cleared", col0, 0);
            check("rst_fs_timing", fs0, (n == 14 || n == 28) ? 1 : 0);
            if (n == 2) check("rst_scan_restart", row0, 7'b0000010);
        end

        // DIV=1 instance with character 3
        reset = 1'b1; sel = 2'd3;
        cycle();
        check("d1_rst_row", row1, 7'b0000001);
        reset = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            if (n <= 7) begin
                wr_en = 1'b1; wr_pat = 2'd3; wr_row = 3'(n - 1); wr_data = 5'(n);
            end else begin
                wr_en = 1'b0;
            end
            cycle();
            check($sformatf("d1_row_n%0d", n), row1, 32'(1 << (n % 7)));
            check($sformatf("d1_fs_n%0d", n), fs1, (n % 7 == 0) ? 1 : 0);
            check($sformatf("d1_col_n%0d", n), col1, (n >= 7) ? (n % 7) + 1 : 0);
        end
        wr_en = 1'b0;

        // Randomised traffic checked against the model only
        for (int i = 0; i < 3000; i++) begin
            reset   = ($urandom_range(299) == 0);
            if ($urandom_range(40) == 0) sel = 2'($urandom);
            if ($urandom_range(150) == 0) blink_en = ~blink_en;
            wr_en   = ($urandom_range(3) == 0);
            wr_pat  = 2'($urandom);
            wr_row  = 3'($urandom);
            wr_data = 5'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
